// File: rtl/mem_responder_pkg.sv
// Shared system parameters for the memory responder and its initiators:
// default geometry and latency, plus the responder state encoding.
package mem_responder_pkg;

    localparam int DEF_MEM_DEPTH  = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_LATENCY    = 2;

    // Wide enough for the largest legal LATENCY (15).
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous write, registered read, no reset.
// Out-of-range addresses read as zero and drop writes.
module mem_resp_array
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;

    assign in_range = {1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // rd_data doubles as the responder's response register.
    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            mem[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= in_range ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder on a shared tri-state data bus with a
// four-phase req_valid/data_valid handshake. Optional err output: MEMRESP_ERR_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic      [ADDR_WIDTH-1:0] Addr,
    input  logic                       we,
    inout  wire logic [DATA_WIDTH-1:0] Data,
    output logic                       data_valid
`ifdef MEMRESP_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    resp_state_t           state;
    resp_state_t           state_next;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  capture;
    logic                  commit;
    logic                  drive;

    assign capture = (state == IDLE) && req_valid;
    // Array access happens on the BUSY->RESP edge.
    assign commit  = (state == BUSY) && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (capture) begin
                addr_q  <= Addr;
                we_q    <= we;
                wdata_q <= we ? Data : '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        data_valid = 1'b0;
        drive      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = BUSY;
                    count_next = CNT_LOAD;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    state_next = RESP;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            RESP: begin
                data_valid = 1'b1;
                drive      = !we_q;
                if (!req_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Data = drive ? resp_data : 'z;

    mem_resp_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk    (clk),
        .wr_en  (commit && we_q),
        .rd_en  (commit && !we_q),
        .addr   (addr_q),
        .wr_data(wdata_q),
        .rd_data(resp_data)
    );

`ifdef MEMRESP_ERR_EN
    logic oor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oor_q <= 1'b0;
        end else if (capture) begin
            oor_q <= !({1'b0, Addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
        end
    end

    assign err = data_valid && oor_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (depth 6/latency 2,
// depth 8/latency 1, depth 8/latency 7) checked against an array model.
module tb_mem_responder;

    localparam int DW = 32;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    rv = '0;
    logic [2:0]    wr = '0;
    logic [2:0]    drv_en = '0;
    logic [2:0]    dv;
    logic [AW-1:0] ad  [3];
    logic [DW-1:0] drv [3];
    wire  [DW-1:0] bus0;
    wire  [DW-1:0] bus1;
    wire  [DW-1:0] bus2;
`ifdef MEMRESP_ERR_EN
    logic [2:0]    err;
`endif

    assign bus0 = drv_en[0] ? drv[0] : 'z;
    assign bus1 = drv_en[1] ? drv[1] : 'z;
    assign bus2 = drv_en[2] ? drv[2] : 'z;

    mem_responder #(.MEM_DEPTH(6), .DATA_WIDTH(DW), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .Addr(ad[0]), .we(wr[0]),
        .Data(bus0), .data_valid(dv[0])
`ifdef MEMRESP_ERR_EN
        , .err(err[0])
`endif
    );

    mem_responder #(.MEM_DEPTH(8), .DATA_WIDTH(DW), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .Addr(ad[1]), .we(wr[1]),
        .Data(bus1), .data_valid(dv[1])
`ifdef MEMRESP_ERR_EN
        , .err(err[1])
`endif
    );

    mem_responder #(.MEM_DEPTH(8), .DATA_WIDTH(DW), .LATENCY(7)) dut_l7 (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .Addr(ad[2]), .we(wr[2]),
        .Data(bus2), .data_valid(dv[2])
`ifdef MEMRESP_ERR_EN
        , .err(err[2])
`endif
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference model: plain word arrays per instance.
    logic [DW-1:0] model [3][8];

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 1 : 7);
    endfunction

    function automatic int depth_of(input int idx);
        return (idx == 0) ? 6 : 8;
    endfunction

    function automatic logic [DW-1:0] bus_of(input int idx);
        return (idx == 0) ? bus0 : ((idx == 1) ? bus1 : bus2);
    endfunction

    function automatic logic [DW-1:0] exp_read(input int idx, input int a);
        return (a < depth_of(idx)) ? model[idx][a] : '0;
    endfunction

    function automatic logic err_of(input int idx);
`ifdef MEMRESP_ERR_EN
        return err[idx];
`else
        return (idx < 0);
`endif
    endfunction

    // Drives one transaction; scrambles Addr/we/Data after capture.
    task automatic run_txn(input int idx, input bit w, input int a, input logic [DW-1:0] d,
                           input int hold, output int lat, output logic [DW-1:0] rdata,
                           output bit stable, output bit bus_ok, output bit drop_ok,
                           output logic err_o);
        logic [DW-1:0] r0;
        @(negedge clk);
        rv[idx] = 1'b1; ad[idx] = AW'(a); wr[idx] = w; drv[idx] = d; drv_en[idx] = w;
        @(posedge clk); #1;
        lat = 0; bus_ok = 1'b1;
        while (dv[idx] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            ad[idx] = AW'($urandom); wr[idx] = 1'($urandom);
            if (w) drv[idx] = $urandom;
            #1;
            if (w && bus_of(idx) !== drv[idx]) bus_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus_of(idx);
        err_o = err_of(idx);
        if (w && rdata !== drv[idx]) bus_ok = 1'b0;
        r0 = rdata;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (dv[idx] !== 1'b1 || bus_of(idx) !== r0) stable = 1'b0;
        end
        @(negedge clk);
        rv[idx] = 1'b0;
        @(posedge clk); #1;
        drop_ok = (dv[idx] === 1'b0);
        drv_en[idx] = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        logic [DW-1:0] d;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drv[i] = $urandom;
            drv_en[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (dv[i] !== 1'b0) begin
                nfail++; $display("FAIL reset_dv[%0d]: got %b expected 0", i, dv[i]);
            end
            nvec++;
            if (bus_of(i) !== drv[i]) begin
                nfail++; $display("FAIL reset_bus_hiz[%0d]: got %h expected %h", i, bus_of(i), drv[i]);
            end
`ifdef MEMRESP_ERR_EN
            nvec++;
            if (err[i] !== 1'b0) begin
                nfail++; $display("FAIL reset_err[%0d]: got %b expected 0", i, err[i]);
            end
`endif
        end
        drv_en = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        d = $urandom;
        run_txn(0, 1'b1, 1, d, 0, lat, rd, st, bo, dr, e);
        model[0][1] = d;
        nvec++;
        if (lat !== 2) begin
            nfail++; $display("FAIL first_req_after_reset: latency %0d expected 2", lat);
        end
    endtask

    task automatic test_latency_sweep();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < depth_of(i); a++) begin
                d = $urandom;
                run_txn(i, 1'b1, a, d, 0, lat, rd, st, bo, dr, e);
                model[i][a] = d;
                nvec++;
                if (lat !== lat_of(i)) begin
                    nfail++; $display("FAIL sweep_wr_latency[%0d]: got %0d expected %0d", i, lat, lat_of(i));
                end
            end
            for (int a = 0; a < depth_of(i); a++) begin
                run_txn(i, 1'b0, a, '0, 0, lat, rd, st, bo, dr, e);
                nvec++;
                if (lat !== lat_of(i)) begin
                    nfail++; $display("FAIL sweep_rd_latency[%0d]: got %0d expected %0d", i, lat, lat_of(i));
                end
                nvec++;
                if (rd !== exp_read(i, a)) begin
                    nfail++; $display("FAIL sweep_rd_data[%0d][%0d]: got %h expected %h", i, a, rd, exp_read(i, a));
                end
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        run_txn(0, 1'b1, 3, 32'hDEADBEEF, 2, lat, rd, st, bo, dr, e);
        model[0][3] = 32'hDEADBEEF;
        nvec++;
        if (bo !== 1'b1) begin
            nfail++; $display("FAIL wr_bus_hiz: bus disturbed=%b expected 0", !bo);
        end
        run_txn(0, 1'b0, 3, '0, 0, lat, rd, st, bo, dr, e);
        nvec++;
        if (lat !== 2) begin
            nfail++; $display("FAIL rd_latency: got %0d expected 2", lat);
        end
        nvec++;
        if (rd !== 32'hDEADBEEF) begin
            nfail++; $display("FAIL rd_deadbeef: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_held_handshake();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        run_txn(0, 1'b0, 4, '0, 5, lat, rd, st, bo, dr, e);
        nvec++;
        if (rd !== exp_read(0, 4)) begin
            nfail++; $display("FAIL held_data: got %h expected %h", rd, exp_read(0, 4));
        end
        nvec++;
        if (st !== 1'b1) begin
            nfail++; $display("FAIL held_stable: got %b expected 1", st);
        end
        nvec++;
        if (dr !== 1'b1) begin
            nfail++; $display("FAIL held_drop: dv low after release=%b expected 1", dr);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        logic [DW-1:0] d;
        for (int k = 0; k < 4; k++) begin
            int i = k % 3;
            int a = $urandom_range(0, depth_of(i) - 1);
            d = $urandom;
            run_txn(i, 1'b1, a, d, 0, lat, rd, st, bo, dr, e);
            model[i][a] = d;
            run_txn(i, 1'b0, a, '0, 0, lat, rd, st, bo, dr, e);
            nvec++;
            if (rd !== d) begin
                nfail++; $display("FAIL raw_b2b[%0d][%0d]: got %h expected %h", i, a, rd, d);
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        run_txn(0, 1'b1, 6, $urandom, 0, lat, rd, st, bo, dr, e);
`ifdef MEMRESP_ERR_EN
        nvec++;
        if (e !== 1'b1) begin
            nfail++; $display("FAIL oor_wr_err: got %b expected 1", e);
        end
`endif
        run_txn(0, 1'b0, 7, '0, 0, lat, rd, st, bo, dr, e);
        nvec++;
        if (rd !== '0) begin
            nfail++; $display("FAIL oor_rd7: got %h expected 0", rd);
        end
`ifdef MEMRESP_ERR_EN
        nvec++;
        if (e !== 1'b1) begin
            nfail++; $display("FAIL oor_rd7_err: got %b expected 1", e);
        end
`endif
        run_txn(0, 1'b0, 6, '0, 0, lat, rd, st, bo, dr, e);
        nvec++;
        if (rd !== '0) begin
            nfail++; $display("FAIL oor_rd6_dropped: got %h expected 0", rd);
        end
        run_txn(0, 1'b0, 2, '0, 0, lat, rd, st, bo, dr, e);
        nvec++;
        if (rd !== exp_read(0, 2)) begin
            nfail++; $display("FAIL inrange_rd2: got %h expected %h", rd, exp_read(0, 2));
        end
`ifdef MEMRESP_ERR_EN
        nvec++;
        if (e !== 1'b0) begin
            nfail++; $display("FAIL inrange_rd2_err: got %b expected 0", e);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        run_txn(0, 1'b1, 5, 32'h0, 0, lat, rd, st, bo, dr, e);
        model[0][5] = '0;
        @(negedge clk);
        rv[0] = 1'b1; ad[0] = 3'd5; wr[0] = 1'b1; drv[0] = 32'h12345678; drv_en[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drv[0] = 32'hA5A5_0F0F;
        #1;
        nvec++;
        if (dv[0] !== 1'b0) begin
            nfail++; $display("FAIL midwr_reset_dv: got %b expected 0", dv[0]);
        end
        nvec++;
        if (bus0 !== drv[0]) begin
            nfail++; $display("FAIL midwr_reset_bus_hiz: got %h expected %h", bus0, drv[0]);
        end
        rv[0] = 1'b0;
        drv_en[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_txn(0, 1'b0, 5, '0, 0, lat, rd, st, bo, dr, e);
        nvec++;
        if (rd !== 32'h0) begin
            nfail++; $display("FAIL midwr_discarded: got %h expected 0", rd);
        end
    endtask

    task automatic test_random();
        int lat; logic [DW-1:0] rd; bit st, bo, dr; logic e;
        logic [DW-1:0] d;
        for (int k = 0; k < 40; k++) begin
            int i = $urandom_range(0, 2);
            int a = $urandom_range(0, 7);
            bit w = 1'($urandom);
            int h = $urandom_range(0, 2);
            d = $urandom;
            run_txn(i, w, a, d, h, lat, rd, st, bo, dr, e);
            nvec++;
            if (lat !== lat_of(i)) begin
                nfail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, lat_of(i));
            end
            if (w) begin
                nvec++;
                if (bo !== 1'b1) begin
                    nfail++; $display("FAIL rnd_wr_bus[%0d]: disturbed=%b expected 0", i, !bo);
                end
                if (a < depth_of(i)) model[i][a] = d;
            end else begin
                nvec++;
                if (rd !== exp_read(i, a)) begin
                    nfail++; $display("FAIL rnd_rd[%0d][%0d]: got %h expected %h", i, a, rd, exp_read(i, a));
                end
            end
            nvec++;
            if (st !== 1'b1 || dr !== 1'b1) begin
                nfail++; $display("FAIL rnd_handshake[%0d]: stable=%b drop=%b expected 1 1", i, st, dr);
            end
`ifdef MEMRESP_ERR_EN
            nvec++;
            if (e !== 1'(a >= depth_of(i))) begin
                nfail++; $display("FAIL rnd_err[%0d][%0d]: got %b expected %b", i, a, e, a >= depth_of(i));
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ad[i] = '0;
            drv[i] = '0;
        end
        test_reset();
        test_latency_sweep();
        test_write_read();
        test_held_handshake();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 8, number of DATA_WIDTH-bit words stored.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request capture to data_valid; legal range 1..15.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), address width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  initiator request strobe, held high until data_valid is seen.
REQ-008 SHALL have port Addr  input  ADDR_WIDTH  word address, valid while req_valid is high.
REQ-009 SHALL have port we  input  1  1=write, 0=read, valid while req_valid is high.
REQ-010 SHALL have port Data  inout  DATA_WIDTH  shared data bus; driven by initiator for writes, by this block for read responses.
REQ-011 SHALL have port data_valid  output  1  response strobe.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-013 IDLE: on req_valid=1, SHALL capture Addr, we and (if we=1) Data into internal registers, load latency counter with LATENCY-1, go to BUSY.
REQ-014 BUSY: SHALL decrement the counter each cycle; at count 0 SHALL go to RESP, committing a captured write to the array on that same edge.
REQ-015 Read data SHALL be read from the array at the BUSY->RESP edge into a response register.
REQ-016 With a request captured at edge k, data_valid SHALL rise after edge k+LATENCY; LATENCY=1 gives data_valid after edge k+1.
REQ-017 RESP: data_valid SHALL be 1; for reads, Data SHALL be driven with the response register; for writes, Data SHALL stay high-Z.
REQ-018 RESP SHALL be held (four-phase handshake) until req_valid is sampled 0, then go to IDLE with data_valid=0 on the next cycle.
REQ-019 Data SHALL be high-Z in every state except RESP-for-read; no cycle with both ends driving.
REQ-020 Changes on Addr, we or Data during BUSY/RESP SHALL be ignored.
REQ-021 req_valid low in BUSY (request abort) SHALL be ignored; the transaction completes, and RESP exits immediately on the first cycle req_valid is low.
REQ-022 Back-to-back requests: a new request SHALL only be captured in IDLE; minimum 1 IDLE cycle between transactions.
REQ-023 Addresses >= MEM_DEPTH (only when MEM_DEPTH is not a power of 2) SHALL read as 0 and drop writes.
REQ-024 Read of a location written by the previous transaction SHALL return the new value.

Reset
REQ-025 On reset, regardless of state: state=IDLE, data_valid=0, Data high-Z, counter=0, captured request cleared.
REQ-026 Reset during BUSY SHALL discard an uncommitted write; array contents SHALL NOT be cleared by reset.
REQ-027 First request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MEMRESP_ERR_EN SHALL, when defined, add output port err (1 bit), valid with data_valid, =1 when the captured address >= MEM_DEPTH, reset value 0.
REQ-029 Without MEMRESP_ERR_EN, port err SHALL not exist; out-of-range behaviour otherwise identical (REQ-023).

Structure
REQ-030 State encodings (IDLE/BUSY/RESP) and default MEM_DEPTH/DATA_WIDTH/LATENCY SHALL live in the shared system parameter header, reused by fetch and any future data-side initiator.
REQ-031 Storage SHALL be a sub-module mem_resp_array (synchronous write port, registered read port, no reset); FSM, counter and tri-state control stay in mem_responder.

Verification
REQ-032 Write then read: write 0xDEADBEEF to addr 3, then read addr 3 -> data_valid after LATENCY cycles, Data=0xDEADBEEF, Data high-Z during the write response.
REQ-033 Latency sweep: LATENCY=1,2,7 -> data_valid rises exactly LATENCY cycles after the capturing edge.
REQ-034 Held handshake: keep req_valid high 5 cycles after data_valid -> data_valid and Data stay stable 5 cycles, drop 1 cycle after req_valid falls.
REQ-035 Reset mid-write: write 0x12345678 to addr 5 (initially 0x0), assert reset in BUSY -> data_valid=0, Data high-Z; subsequent read of addr 5 returns 0x0.
REQ-036 Out of range with MEMRESP_ERR_EN, MEM_DEPTH=6: read addr 7 -> Data=0, err=1; read addr 2 -> err=0.
REQ-037 Initiator loop: connect to fetch with preloaded 8 words -> opcodes emitted in address order 0..7 then wrap, no bus contention flagged (no X on Data).
